// File: rtl/mpp_suffix_sched_pkg.sv
// Shared constants, FSM state and group record for the MPP suffix scheduler.
// A block is 4 groups of 12 residuals; each residual carries 5..8 suffix bits.
package mpp_suffix_sched_pkg;

    localparam int MPP_GRP_SAMPLES = 12;
    localparam int MPP_NUM_GRP     = 4;
    localparam int MIN_BITS        = 5;
    localparam int MAX_BITS        = 8;
    localparam int RES_W           = 8;
    localparam int GRP_W           = MPP_GRP_SAMPLES * RES_W;
    localparam int WIN_W           = 128;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    typedef struct packed {
        logic [1:0]       idx;
        logic [GRP_W-1:0] samples;
    } grp_t;

    // Bits consumed per group: 12 residuals of 'bits' each.
    function automatic logic [7:0] need_of(input logic [3:0] bits);
        return 8'(bits) * 8'(MPP_GRP_SAMPLES);
    endfunction

    function automatic logic bits_ok(input logic [3:0] bits);
        return (bits >= 4'(MIN_BITS)) && (bits <= 4'(MAX_BITS));
    endfunction

endpackage

// File: rtl/mpp_bit_buf.sv
// MSB-aligned bit buffer: drops 'consume' bits from the top and appends a
// feed word right after the surviving bits, both in the same cycle.
module mpp_bit_buf #(
    parameter int BUF_W  = 192,
    parameter int WORD_W = 64,
    parameter int WIN_W  = 128,
    parameter int FILL_W = $clog2(BUF_W + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic [FILL_W-1:0] consume,
    input  logic [WORD_W-1:0] word,
    input  logic              word_valid,
    output logic [WIN_W-1:0]  win,
    output logic [FILL_W-1:0] fill
);

    logic [BUF_W-1:0]  buf_q;
    logic [BUF_W-1:0]  buf_nxt;
    logic [BUF_W-1:0]  word_ext;
    logic [FILL_W-1:0] fill_q;
    logic [FILL_W-1:0] fill_rem;

    // Everything below 'fill' is kept zero, so an OR is enough to append.
    always_comb begin
        fill_rem = fill_q - consume;
        word_ext = {word, {(BUF_W-WORD_W){1'b0}}};
        buf_nxt  = buf_q << consume;
        if (word_valid)
            buf_nxt = buf_nxt | (word_ext >> fill_rem);
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            buf_q  <= '0;
            fill_q <= '0;
        end else begin
            buf_q  <= buf_nxt;
            fill_q <= fill_rem + (word_valid ? FILL_W'(WORD_W) : '0);
        end
    end

    assign win  = buf_q[BUF_W-1 -: WIN_W];
    assign fill = fill_q;

endmodule

// File: rtl/mpp_suffix_sched.sv
// Schedules the 4 suffix-parse groups of one MPP block over a refilled bit
// buffer and hands each parsed group downstream with valid/ready.
module mpp_suffix_sched
    import mpp_suffix_sched_pkg::*;
#(
    parameter int BUF_W   = 192,
    parameter int WORD_W  = 64,
    parameter int NUM_GRP = MPP_NUM_GRP
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              blk_start,
    output logic              blk_ready,
    input  logic [3:0]        bitDepth,
    input  logic [3:0]        stepSize,
    input  logic [WORD_W-1:0] bs_data,
    input  logic              bs_valid,
    output logic              bs_ready,
    output logic [WIN_W-1:0]  sfx_win,
    output logic [3:0]        sfx_bits,
    input  logic [GRP_W-1:0]  sfx_vals,
    output logic              grp_valid,
    input  logic              grp_ready,
    output logic [1:0]        grp_idx,
    output logic [GRP_W-1:0]  grp_samples,
    output logic              blk_done,
    output logic              cfg_err
);

    localparam int         FILL_W   = $clog2(BUF_W + 1);
    localparam logic [1:0] LAST_GRP = 2'(NUM_GRP - 1);

    state_t            state;
    grp_t              grp_q;
    logic [1:0]        grp_cnt;
    logic [3:0]        bits_q;
    logic [FILL_W-1:0] need;
    logic [FILL_W-1:0] fill;
    logic [FILL_W-1:0] fill_rem;
    logic [FILL_W-1:0] consume;
    logic              fire;
    logic              word_take;

    assign need    = FILL_W'(need_of(bits_q));
    assign fire    = (state == RUN) && (fill >= need) && (!grp_valid || grp_ready);
    assign consume = fire ? need : '0;
    assign fill_rem = fill - consume;
    // Not accepting during reset/flush keeps a word from being silently lost.
    assign bs_ready  = !(rst || flush) && (fill_rem <= FILL_W'(BUF_W - WORD_W));
    assign word_take = bs_valid && bs_ready;

    mpp_bit_buf #(
        .BUF_W (BUF_W),
        .WORD_W(WORD_W),
        .WIN_W (WIN_W),
        .FILL_W(FILL_W)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .clr       (flush),
        .consume   (consume),
        .word      (bs_data),
        .word_valid(word_take),
        .win       (sfx_win),
        .fill      (fill)
    );

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            state     <= IDLE;
            grp_q     <= '0;
            grp_cnt   <= '0;
            grp_valid <= 1'b0;
            blk_ready <= 1'b1;
            blk_done  <= 1'b0;
            cfg_err   <= 1'b0;
            if (rst)
                bits_q <= '0;
        end else begin
            blk_done <= 1'b0;
            cfg_err  <= 1'b0;
            if (fire) begin
                grp_q.samples <= sfx_vals;
                grp_q.idx     <= grp_cnt;
                grp_valid     <= 1'b1;
                grp_cnt       <= grp_cnt + 2'd1;
            end else if (grp_valid && grp_ready) begin
                grp_valid <= 1'b0;
            end
            case (state)
                IDLE: if (blk_start) begin
                    bits_q <= bitDepth - stepSize;
                    if (bits_ok(bitDepth - stepSize)) begin
                        state     <= RUN;
                        grp_cnt   <= '0;
                        blk_ready <= 1'b0;
                    end else begin
                        cfg_err <= 1'b1;
                    end
                end
                RUN: if (fire && grp_cnt == LAST_GRP)
                    state <= DRAIN;
                DRAIN: if (grp_valid && grp_ready) begin
                    state    <= DONE;
                    blk_done <= 1'b1;
                end
                DONE: begin
                    state     <= IDLE;
                    blk_ready <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign sfx_bits    = bits_q;
    assign grp_idx     = grp_q.idx;
    assign grp_samples = grp_q.samples;

endmodule

// File: tb/tb_mpp_suffix_sched.sv
// Bench for mpp_suffix_sched: models the suffix parser and the bitstream,
// scoreboards every group against a golden parse of the concatenated stream.
module tb_mpp_suffix_sched;

    logic         clk = 1'b0;
    logic         rst, flush, blk_start, blk_ready;
    logic [3:0]   bitDepth, stepSize;
    logic [63:0]  bs_data;
    logic         bs_valid, bs_ready;
    logic [127:0] sfx_win;
    logic [3:0]   sfx_bits;
    logic [95:0]  sfx_vals;
    logic         grp_valid, grp_ready;
    logic [1:0]   grp_idx;
    logic [95:0]  grp_samples;
    logic         blk_done, cfg_err;

    mpp_suffix_sched dut (
        .clk(clk), .rst(rst), .flush(flush), .blk_start(blk_start), .blk_ready(blk_ready),
        .bitDepth(bitDepth), .stepSize(stepSize), .bs_data(bs_data), .bs_valid(bs_valid),
        .bs_ready(bs_ready), .sfx_win(sfx_win), .sfx_bits(sfx_bits), .sfx_vals(sfx_vals),
        .grp_valid(grp_valid), .grp_ready(grp_ready), .grp_idx(grp_idx),
        .grp_samples(grp_samples), .blk_done(blk_done), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  idx;
        logic [95:0] s;
    } exp_t;

    typedef struct {
        logic [3:0] bd;
        logic [3:0] ss;
        int         nw;
        int         gap;
        bit         err;
    } vec_t;

    int          checks = 0;
    int          failures = 0;
    int          done_cnt = 0;
    int          err_cnt = 0;
    int          gap = 0;
    logic [63:0] tx_q[$];
    bit          gold[$];
    exp_t        exp_q[$];
    exp_t        mon_e;
    vec_t        vt[4];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s: timed out", name);
    endtask

    // Suffix parser model: 12 fields of b bits from the window MSB, zero-extended.
    function automatic logic [95:0] parse(input logic [127:0] w, input logic [3:0] b);
        logic [95:0] r;
        logic [7:0]  v;
        int          bi;
        r  = '0;
        bi = int'(b);
        if (bi >= 1 && bi <= 8)
            for (int i = 0; i < 12; i++) begin
                v = '0;
                for (int k = 0; k < bi; k++) v = {v[6:0], w[127 - i*bi - k]};
                r[95 - 8*i -: 8] = v;
            end
        return r;
    endfunction

    function automatic logic [127:0] gold_win();
        logic [127:0] w;
        for (int k = 0; k < 128; k++) w[127-k] = (k < gold.size()) ? gold[k] : 1'b0;
        return w;
    endfunction

    always_comb sfx_vals = parse(sfx_win, sfx_bits);

    task automatic send_words(input int n);
        logic [63:0] w;
        for (int i = 0; i < n; i++) begin
            w = {$urandom, $urandom};
            tx_q.push_back(w);
            for (int k = 63; k >= 0; k--) gold.push_back(w[k]);
        end
    endtask

    // Golden groups come straight off the stream; stops early if the stream runs short.
    task automatic push_block_exp(input logic [3:0] b);
        exp_t e;
        int   need;
        need = 12 * int'(b);
        for (int g = 0; g < 4; g++) begin
            if (gold.size() < need) break;
            e.idx = 2'(g);
            e.s   = parse(gold_win(), b);
            exp_q.push_back(e);
            repeat (need) void'(gold.pop_front());
        end
    endtask

    // Feed: one word offered at a time, 'gap' idle cycles after each accept.
    initial begin
        int   cd;
        logic acc;
        bs_valid = 1'b0;
        bs_data  = '0;
        cd       = 0;
        forever begin
            @(negedge clk);
            acc = bs_valid && bs_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                void'(tx_q.pop_front());
                cd = gap;
            end else if (cd > 0) begin
                cd--;
            end
            if (tx_q.size() > 0 && cd == 0) begin
                bs_valid = 1'b1;
                bs_data  = tx_q[0];
            end else begin
                bs_valid = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (blk_done) done_cnt++;
            if (cfg_err) err_cnt++;
            if (grp_valid && grp_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL grp_unexpected: got idx %0d expected no group", grp_idx);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("grp_idx", 128'(grp_idx), 128'(mon_e.idx));
                    check("grp_samples", 128'(grp_samples), 128'(mon_e.s));
                end
            end
        end
    end

    task automatic start_block(input logic [3:0] bd, input logic [3:0] ss);
        @(posedge clk); #1;
        blk_start = 1'b1;
        bitDepth  = bd;
        stepSize  = ss;
        @(posedge clk); #1;
        blk_start = 1'b0;
    endtask

    task automatic wait_done(input int d0);
        int n = 0;
        while (done_cnt == d0 && n < 3000) begin @(negedge clk); n++; end
        if (done_cnt == d0) timeout_fail("blk_done_wait");
    endtask

    task automatic wait_feed();
        int n = 0;
        while ((tx_q.size() != 0 || bs_valid) && n < 1000) begin @(negedge clk); n++; end
        if (tx_q.size() != 0) timeout_fail("feed_drain_wait");
    endtask

    task automatic wait_grp();
        int n = 0;
        @(negedge clk);
        while (!grp_valid && n < 1000) begin @(negedge clk); n++; end
        if (!grp_valid) timeout_fail("grp_valid_wait");
    endtask

    task automatic run_row(input vec_t v);
        int         d0, e0;
        logic [3:0] b;
        b   = v.bd - v.ss;
        gap = v.gap;
        d0  = done_cnt;
        e0  = err_cnt;
        send_words(v.nw);
        if (!v.err) push_block_exp(b);
        start_block(v.bd, v.ss);
        if (v.err) begin
            repeat (3) @(negedge clk);
            check("cfg_err_pulse", 128'(err_cnt), 128'(e0 + 1));
            check("cfg_err_stays_idle", 128'(blk_ready), 128'(1));
            check("cfg_err_no_done", 128'(done_cnt), 128'(d0));
            check("cfg_err_no_group", 128'(grp_valid), 128'(0));
            check("cfg_err_bits_latched", 128'(sfx_bits), 128'(b));
        end else begin
            wait_done(d0);
            wait_feed();
            repeat (4) @(negedge clk);
            check("blk_done_once", 128'(done_cnt), 128'(d0 + 1));
            check("all_groups_seen", 128'(exp_q.size()), 128'(0));
            check("no_cfg_err", 128'(err_cnt), 128'(e0));
            check("sfx_bits", 128'(sfx_bits), 128'(b));
            check("leftover_window", sfx_win, gold_win());
            check("idle_after_block", 128'(blk_ready), 128'(1));
        end
    endtask

    initial begin
        int d0;
        rst = 1'b1; flush = 1'b0; blk_start = 1'b0;
        bitDepth = '0; stepSize = '0; grp_ready = 1'b1;
        vt[0] = '{bd: 4'd8,  ss: 4'd0, nw: 6, gap: 0, err: 1'b0};
        vt[1] = '{bd: 4'd8,  ss: 4'd3, nw: 4, gap: 0, err: 1'b0};
        vt[2] = '{bd: 4'd8,  ss: 4'd4, nw: 0, gap: 0, err: 1'b1};
        vt[3] = '{bd: 4'd13, ss: 4'd6, nw: 5, gap: 2, err: 1'b0};
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_blk_ready", 128'(blk_ready), 128'(1));
        check("rst_grp_valid", 128'(grp_valid), 128'(0));
        check("rst_grp_idx", 128'(grp_idx), 128'(0));
        check("rst_grp_samples", 128'(grp_samples), 128'(0));
        check("rst_blk_done", 128'(blk_done), 128'(0));
        check("rst_cfg_err", 128'(cfg_err), 128'(0));
        check("rst_sfx_win", sfx_win, 128'(0));
        check("rst_sfx_bits", 128'(sfx_bits), 128'(0));
        check("rst_bs_ready", 128'(bs_ready), 128'(1));

        for (int i = 0; i < 4; i++) run_row(vt[i]);

        // Backpressure on group 1, with an ignored blk_start while busy.
        gap = 0;
        grp_ready = 1'b0;
        send_words(6);
        push_block_exp(4'd8);
        d0 = done_cnt;
        start_block(4'd8, 4'd0);
        wait_grp();
        check("bp_first_idx", 128'(grp_idx), 128'(0));
        @(posedge clk); #1 grp_ready = 1'b1;
        @(posedge clk); #1 grp_ready = 1'b0;
        wait_grp();
        for (int h = 0; h < 5; h++) begin
            @(posedge clk); #1;
            blk_start = (h == 1);
            bitDepth  = (h == 1) ? 4'd5 : 4'd8;
            @(negedge clk);
            check("hold_valid", 128'(grp_valid), 128'(1));
            check("hold_idx", 128'(grp_idx), 128'(exp_q[0].idx));
            check("hold_samples", 128'(grp_samples), 128'(exp_q[0].s));
        end
        check("hold_bs_ready_low", 128'(bs_ready), 128'(0));
        check("busy_start_ignored", 128'(sfx_bits), 128'(8));
        @(posedge clk); #1;
        blk_start = 1'b0;
        bitDepth  = 4'd8;
        grp_ready = 1'b1;
        wait_done(d0);
        wait_feed();
        repeat (3) @(negedge clk);
        check("bp_done_once", 128'(done_cnt), 128'(d0 + 1));
        check("bp_all_groups", 128'(exp_q.size()), 128'(0));
        check("bp_leftover_window", sfx_win, gold_win());

        // Flush after group 2: block aborted, buffer emptied.
        send_words(5);
        push_block_exp(4'd8);
        d0 = done_cnt;
        start_block(4'd8, 4'd0);
        begin
            int n = 0;
            while (exp_q.size() != 0 && n < 2000) begin @(negedge clk); n++; end
            if (exp_q.size() != 0) timeout_fail("flush_groups_wait");
        end
        @(posedge clk); #1 flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        @(negedge clk);
        check("flush_idle", 128'(blk_ready), 128'(1));
        check("flush_grp_valid", 128'(grp_valid), 128'(0));
        check("flush_window_empty", sfx_win, 128'(0));
        check("flush_bs_ready", 128'(bs_ready), 128'(1));
        check("flush_keeps_bits", 128'(sfx_bits), 128'(8));
        gold.delete();
        repeat (5) @(negedge clk);
        check("flush_no_done", 128'(done_cnt), 128'(d0));
        check("flush_no_group", 128'(grp_valid), 128'(0));

        run_row('{bd: 4'd9, ss: 4'd3, nw: 5, gap: 1, err: 1'b0});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
